// File: rtl/traffic_demand_monitor.sv
// Demand stage for the intersection light controller: lane/pedestrian wait counts, demand flags, emergency conditioning.
// Define DEMAND_SYNC_EN to put 2-flop synchronizers on the raw arrival and emergency inputs.
module traffic_demand_monitor #(
    parameter int DEPART_TICKS = 4,
    parameter int ABS_THRESH   = 5,
    parameter int P_THRESH     = 3,
    parameter int MORE_MARGIN  = 2,
    parameter int EMG_HOLD     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m_arr,
    input  logic       l_arr,
    input  logic       s_arr,
    input  logic       p_arr,
    input  logic       m_go,
    input  logic       l_go,
    input  logic       s_go,
    input  logic       p_go,
    input  logic       emg_req,
    output logic [2:0] main_num,
    output logic [2:0] left_num,
    output logic [2:0] sec_num,
    output logic [2:0] p_num,
    output logic       m_more,
    output logic       l_zero,
    output logic       s_more,
    output logic       p_more,
    output logic [2:0] absolute_num,
    output logic       s_emergency
);

    localparam logic [3:0] DEPART_LAST = 4'(DEPART_TICKS - 1);
    localparam logic [3:0] ABS_LEVEL   = 4'(ABS_THRESH);
    localparam logic [3:0] P_LEVEL     = 4'(P_THRESH);
    localparam logic [3:0] MARGIN      = 4'(MORE_MARGIN);
    localparam logic [4:0] HOLD_LOAD   = 5'(EMG_HOLD - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} emg_state_t;

    logic [3:0] arr_raw;
    logic [3:0] arr_sync;
    logic       emg_sync;
    logic [3:0] arr_prev;
    logic [3:0] arr_evt;

    assign arr_raw = {p_arr, s_arr, l_arr, m_arr};

`ifdef DEMAND_SYNC_EN
    logic [4:0] sync_a;
    logic [4:0] sync_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {emg_req, arr_raw};
            sync_b <= sync_a;
        end
    end

    assign arr_sync = sync_b[3:0];
    assign emg_sync = sync_b[4];
`else
    assign arr_sync = arr_raw;
    assign emg_sync = emg_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) arr_prev <= '0;
        else     arr_prev <= arr_sync;
    end

    assign arr_evt = arr_sync & ~arr_prev;

    // Vehicle lanes indexed 0 = main, 1 = left, 2 = secondary.
    logic [2:0] veh_go;
    logic [2:0] veh_dep;
    logic [3:0] veh_timer [3];
    logic [2:0] veh_cnt   [3];

    assign veh_go = {s_go, l_go, m_go};

    always_comb begin
        veh_dep = '0;
        for (int i = 0; i < 3; i++)
            veh_dep[i] = veh_go[i] && (veh_timer[i] == DEPART_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                veh_timer[i] <= '0;
                veh_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!veh_go[i] || veh_dep[i]) veh_timer[i] <= '0;
                else                          veh_timer[i] <= veh_timer[i] + 4'd1;
                // A simultaneous arrival and departure cancel out.
                if (arr_evt[i] && !veh_dep[i]) begin
                    if (veh_cnt[i] != 3'd7) veh_cnt[i] <= veh_cnt[i] + 3'd1;
                end else if (veh_dep[i] && !arr_evt[i]) begin
                    if (veh_cnt[i] != 3'd0) veh_cnt[i] <= veh_cnt[i] - 3'd1;
                end
            end
        end
    end

    assign main_num = veh_cnt[0];
    assign left_num = veh_cnt[1];
    assign sec_num  = veh_cnt[2];

    // Walk phase empties the pedestrian queue and swallows any arrival seen meanwhile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           p_num <= '0;
        else if (p_go)                     p_num <= '0;
        else if (arr_evt[3] && p_num != 3'd7) p_num <= p_num + 3'd1;
    end

    logic [3:0] main_w, sec_w, left_w, ped_w;
    assign main_w = {1'b0, main_num};
    assign sec_w  = {1'b0, sec_num};
    assign left_w = {1'b0, left_num};
    assign ped_w  = {1'b0, p_num};

    assign m_more       = main_w > (sec_w + MARGIN);
    assign s_more       = sec_w > (main_w + MARGIN);
    assign l_zero       = (left_num == 3'd0);
    assign p_more       = ped_w >= P_LEVEL;
    assign absolute_num = {main_w >= ABS_LEVEL, sec_w >= ABS_LEVEL, left_w >= ABS_LEVEL};

    emg_state_t state, state_next;
    logic [4:0] hold_cnt, hold_next;

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        case (state)
            IDLE:   if (emg_sync) state_next = ACTIVE;
            ACTIVE: if (!emg_sync) begin
                        state_next = HOLD;
                        hold_next  = HOLD_LOAD;
                    end
            HOLD:   if (emg_sync)              state_next = ACTIVE;
                    else if (hold_cnt == 5'd0) state_next = IDLE;
                    else                       hold_next  = hold_cnt - 5'd1;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            s_emergency <= 1'b0;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_next;
            s_emergency <= (state_next != IDLE);
        end
    end

endmodule

// File: doc/traffic_demand_monitor.md
# traffic_demand_monitor

Upstream demand stage for the intersection light controller. Counts vehicles waiting on the main, left-turn and secondary approaches, plus pedestrians waiting, from raw detector pulses. Drains each count while its lane is being served. Derives the relative demand flags (m_more, l_zero, s_more, p_more), the absolute demand vector and the conditioned emergency request that the light controller consumes each cycle.

## Interface
Parameters:
- DEPART_TICKS, 4: cycles per departing vehicle while a lane is served; legal range 1..15.
- ABS_THRESH, 5: count at or above which a lane is heavy in absolute_num; legal range 1..7.
- P_THRESH, 3: p_num at or above which p_more asserts; legal range 1..7.
- MORE_MARGIN, 2: lead required for m_more/s_more; legal range 0..3.
- EMG_HOLD, 8: cycles s_emergency stays high after the request drops; legal range 1..31.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- m_arr, l_arr, s_arr, p_arr  in  1 each  raw arrival detectors; one arrival per rising edge.
- m_go, l_go, s_go, p_go  in  1 each  lane currently served (green / left arrow / walk), from the light controller.
- emg_req  in  1  raw emergency-vehicle request, level.
- main_num, left_num, sec_num, p_num  out  3 each  waiting counts, saturating 0..7.
- m_more, l_zero, s_more, p_more  out  1 each  relative demand flags.
- absolute_num  out  3  {main heavy, sec heavy, left heavy}.
- s_emergency  out  1  conditioned emergency request.

## Operation
- Input conditioning: each raw input (arrivals, emg_req) passes a 2-flop synchronizer (see Configuration). Each arrival has a prev register; arrival event = sync & ~prev.
- Vehicle lanes (main, left, sec):
  - An arrival increments the count, saturating at 7.
  - While the go input is high, a per-lane 4-bit timer counts. When the timer reaches DEPART_TICKS-1, it returns to 0 and the count decrements, saturating at 0.
  - The timer clears to 0 on any cycle go is low.
  - An arrival and a departure on the same edge leave the count unchanged.
- Pedestrian lane:
  - p_arr increments p_num, saturating at 7.
  - Any cycle p_go is high clears p_num to 0 at the next edge.
  - Arrivals while p_go is high are dropped.
- Flags: combinational from the count registers; all comparisons use 4-bit unsigned arithmetic.
  - m_more = main_num > sec_num + MORE_MARGIN.
  - s_more = sec_num > main_num + MORE_MARGIN.
  - l_zero = (left_num == 0).
  - p_more = p_num >= P_THRESH.
  - absolute_num[2] = main_num >= ABS_THRESH; absolute_num[1] = sec_num >= ABS_THRESH; absolute_num[0] = left_num >= ABS_THRESH.
- Emergency state machine, states IDLE, ACTIVE, HOLD:
  - IDLE -> ACTIVE when synced emg_req = 1.
  - ACTIVE -> HOLD when synced emg_req = 0; the 5-bit hold counter loads EMG_HOLD-1.
  - HOLD -> ACTIVE if synced emg_req returns to 1.
  - HOLD -> IDLE when the counter is 0; otherwise the counter decrements.
  - s_emergency = (state != IDLE), registered.
- Reset (asynchronous, mid-operation included):
  - Counts, timers, synchronizers, prev registers and hold counter go to 0; state goes to IDLE.
  - Outputs after reset: counts 0, m_more/s_more/p_more 0, l_zero 1, absolute_num 3'b000, s_emergency 0.

## Timing
- With synchronizers: raw input first sampled high at edge k gives an updated count after edge k+2.
- Without synchronizers: the count updates at edge k.
- Flags follow their counts in the same cycle; there is no extra latency.
- A held-high arrival input counts once. The input must be low for at least one sampled cycle before the next arrival counts.
- Departure: go high at edges 1..N gives decrements after edges DEPART_TICKS, 2*DEPART_TICKS, and so on.
- Emergency:
  - s_emergency rises 1 edge after synced emg_req.
  - After synced emg_req drops, s_emergency stays high for exactly EMG_HOLD further cycles, then falls.

## Configuration
- DEMAND_SYNC_EN defined: the 2-flop synchronizers are present on all raw inputs (arrivals and emg_req).
- DEMAND_SYNC_EN undefined: raw inputs are treated as synchronous to clk and feed the edge/state logic directly, reducing latency by 2 cycles. All other behaviour is identical.

## Test plan
- Reset: assert rst mid-count with main_num=4 -> all counts 0, l_zero=1, absolute_num=000, s_emergency=0 immediately (asynchronous).
- Saturation: 9 m_arr pulses, no m_go -> main_num=7, absolute_num[2]=1, m_more=1 (sec_num=0).
- Departure and simultaneity:
  - sec_num=3, s_go high 12 cycles, DEPART_TICKS=4 -> sec_num 2, 1, 0 at cycles 4, 8, 12.
  - An s_arr on the cycle-8 departure edge -> sec_num stays 2.
- Pedestrian: 3 p_arr pulses -> p_num=3, p_more=1; one cycle of p_go -> p_num=0, p_more=0; p_arr during p_go is ignored.
- Emergency: emg_req high 5 cycles then low, EMG_HOLD=8 -> s_emergency high from 1 edge after synced request until 8 cycles after synced drop; a re-assert during HOLD keeps it high continuously.
- Flags margin: main_num=5, sec_num=3, MORE_MARGIN=2 -> m_more=0; one more main arrival -> m_more=1, s_more=0.
